// File: rtl/logic_capture_pkg.sv
// Shared constants for the logic analyser capture block:
// state codes, register bit-field offsets and trigger pattern codes.
package logic_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int CTL_START   = 0;
   localparam int CTL_ABORT   = 1;

   localparam int C0_CH_LSB   = 0;
   localparam int C0_RISE     = 3;
   localparam int C0_EDGE_EN  = 4;
   localparam int C0_PAT_LSB  = 16;

   localparam int C1_PRE_LSB  = 0;
   localparam int C1_POST_LSB = 16;

   localparam int ST_STATE_LSB = 0;
   localparam int ST_DONE_BIT  = 3;
   localparam int ST_TRIG_BIT  = 4;

   localparam logic [1:0] PAT_ANY  = 2'b00;
   localparam logic [1:0] PAT_LOW  = 2'b01;
   localparam logic [1:0] PAT_HIGH = 2'b10;
   localparam logic [1:0] PAT_CHG  = 2'b11;

   function automatic logic pat_ok(
      input logic [1:0] code,
      input logic       s,
      input logic       p
   );
      logic ok;
      ok = 1'b1;
      case (code)
         PAT_ANY:  ok = 1'b1;
         PAT_LOW:  ok = ~s;
         PAT_HIGH: ok = s;
         PAT_CHG:  ok = s ^ p;
         default:  ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/logic_capture_trigger.sv
// Combinational trigger evaluation: edge condition on one channel,
// qualified by per-channel pattern codes when PATTERN_TRIGGER_EN is defined.
module lc_trigger
   import logic_capture_pkg::*;
(
   input  logic [7:0]  s,
   input  logic [7:0]  p,
   input  logic [31:0] config0,
   output logic        fire
);

   logic [2:0] ch;
   logic       edge_ok;
   logic       pat_all;
   logic       unused_cfg;

   assign ch = config0[C0_CH_LSB +: 3];

   always_comb begin
      edge_ok = 1'b1;
      if (config0[C0_EDGE_EN]) begin
         if (config0[C0_RISE])
            edge_ok = s[ch] & ~p[ch];
         else
            edge_ok = ~s[ch] & p[ch];
      end
   end

`ifdef PATTERN_TRIGGER_EN
   always_comb begin
      pat_all = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (!pat_ok(config0[C0_PAT_LSB + 2*k +: 2], s[k], p[k]))
            pat_all = 1'b0;
      end
   end
   assign unused_cfg = ^config0[15:5];
`else
   // Pattern field is deliberately ignored in this build.
   assign pat_all    = 1'b1;
   assign unused_cfg = ^config0[31:5];
`endif

   assign fire = edge_ok & pat_all;

endmodule

// File: rtl/logic_capture.sv
// Logic analyser capture controller: pre-trigger fill, armed ring
// buffering, post-trigger fill. Optional macro: PATTERN_TRIGGER_EN.
module logic_capture
   import logic_capture_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       control,
   input  logic [31:0]       config0,
   input  logic [31:0]       config1,
   input  logic [7:0]        datain,
   output logic [31:0]       status,
   output logic [31:0]       status1,
   output logic [7:0]        dataout,
   output logic              we,
   output logic              en,
   output logic [ADDR_W-1:0] address
);

   state_t            state;
   logic [7:0]        s;
   logic [7:0]        p;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] trig_addr;
   logic              triggered;
   logic              done;
   logic              start_d;
   logic              fire;
   logic              start_rise;
   logic              abort;
   logic              writing;
   logic [ADDR_W-1:0] pre_n;
   logic [ADDR_W-1:0] post_n;
   logic              unused_ctl;

   assign pre_n      = config1[C1_PRE_LSB +: ADDR_W];
   assign post_n     = config1[C1_POST_LSB +: ADDR_W];
   assign start_rise = control[CTL_START] & ~start_d;
   assign abort      = control[CTL_ABORT];
   assign unused_ctl = ^control[31:2];

   lc_trigger u_trig (
      .s       (s),
      .p       (p),
      .config0 (config0),
      .fire    (fire)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         s         <= '0;
         p         <= '0;
         addr      <= '0;
         cnt       <= '0;
         trig_addr <= '0;
         triggered <= 1'b0;
         done      <= 1'b0;
         start_d   <= 1'b0;
      end else begin
         s       <= datain;
         p       <= s;
         start_d <= control[CTL_START];
         if (abort) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (start_rise) begin
                     addr      <= '0;
                     cnt       <= '0;
                     triggered <= 1'b0;
                     done      <= 1'b0;
                     state     <= (pre_n == '0) ? ST_ARMED : ST_PRE;
                  end
               end
               ST_PRE: begin
                  addr <= addr + 1'b1;
                  // Zero re-check covers a live config change mid-fill.
                  if (pre_n == '0 || cnt == pre_n - 1'b1) begin
                     cnt   <= '0;
                     state <= ST_ARMED;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_ARMED: begin
                  addr <= addr + 1'b1;
                  if (fire) begin
                     trig_addr <= addr;
                     triggered <= 1'b1;
                     cnt       <= '0;
                     if (post_n == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end else begin
                        state <= ST_POST;
                     end
                  end
               end
               ST_POST: begin
                  addr <= addr + 1'b1;
                  if (post_n == '0 || cnt == post_n - 1'b1) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign writing = (state == ST_PRE) ||
                    (state == ST_ARMED) ||
                    (state == ST_POST);

   assign we      = writing;
   assign en      = writing;
   assign address = addr;
   assign dataout = s;

   always_comb begin
      status = '0;
      status[ST_STATE_LSB +: 3] = state;
      status[ST_DONE_BIT]       = done;
      status[ST_TRIG_BIT]       = triggered;
   end

   assign status1 = {16'(addr), 16'(trig_addr)};

endmodule

// File: tb/tb_logic_capture.sv
// Directed bench for logic_capture: vector table for FSM sequencing,
// hand-written sequences for trigger, pattern, reset and wrap cases.
module tb_logic_capture;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] control;
   logic [31:0] config0;
   logic [31:0] config1;
   logic [7:0]  datain;
   logic [31:0] status;
   logic [31:0] status1;
   logic [7:0]  dataout;
   logic        we;
   logic        en;
   logic [15:0] address;

   int n_chk  = 0;
   int n_pass = 0;

   logic_capture #(.ADDR_W(16)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .control (control),
      .config0 (config0),
      .config1 (config1),
      .datain  (datain),
      .status  (status),
      .status1 (status1),
      .dataout (dataout),
      .we      (we),
      .en      (en),
      .address (address)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ctrl;
      logic [31:0] cfg0;
      logic [31:0] cfg1;
      logic [2:0]  st;
      logic        we;
      logic [15:0] addr;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_status"},  status,  32'h0);
      check({tag, "_status1"}, status1, 32'h0);
      check({tag, "_dataout"}, {24'h0, dataout}, 32'h0);
      check({tag, "_we"},      {31'h0, we}, 32'h0);
      check({tag, "_en"},      {31'h0, en}, 32'h0);
      check({tag, "_addr"},    {16'h0, address}, 32'h0);
   endtask

   initial begin
      int posts;
      // ctrl, cfg0, cfg1, state, we, address
      tbl[0]  = '{32'h1, 32'h0,  32'h0,         3'd2, 1'b1, 16'd0};
      tbl[1]  = '{32'h0, 32'h0,  32'h0,         3'd4, 1'b0, 16'd1};
      tbl[2]  = '{32'h0, 32'h0,  32'h0,         3'd4, 1'b0, 16'd1};
      tbl[3]  = '{32'h1, 32'h0,  32'h00FF0000,  3'd2, 1'b1, 16'd0};
      tbl[4]  = '{32'h0, 32'h0,  32'h00FF0000,  3'd3, 1'b1, 16'd1};
      tbl[5]  = '{32'h0, 32'h0,  32'h00FF0000,  3'd3, 1'b1, 16'd2};
      tbl[6]  = '{32'h2, 32'h0,  32'h00FF0000,  3'd0, 1'b0, 16'd2};
      tbl[7]  = '{32'h3, 32'h0,  32'h00FF0000,  3'd0, 1'b0, 16'd2};
      tbl[8]  = '{32'h0, 32'h0,  32'h00FF0000,  3'd0, 1'b0, 16'd2};
      tbl[9]  = '{32'h1, 32'h18, 32'h00000003,  3'd1, 1'b1, 16'd0};
      tbl[10] = '{32'h1, 32'h18, 32'h00000003,  3'd1, 1'b1, 16'd1};
      tbl[11] = '{32'h1, 32'h18, 32'h00000003,  3'd1, 1'b1, 16'd2};
      tbl[12] = '{32'h1, 32'h18, 32'h00000003,  3'd2, 1'b1, 16'd3};
      tbl[13] = '{32'h0, 32'h18, 32'h00000003,  3'd2, 1'b1, 16'd4};
      tbl[14] = '{32'h1, 32'h18, 32'h00000003,  3'd2, 1'b1, 16'd5};

      resetn  = 1'b0;
      control = '0;
      config0 = '0;
      config1 = '0;
      datain  = '0;
      tick();
      tick();
      check_reset_outputs("reset");
      resetn = 1'b1;

      for (int i = 0; i < 15; i++) begin
         control = tbl[i].ctrl;
         config0 = tbl[i].cfg0;
         config1 = tbl[i].cfg1;
         tick();
         check($sformatf("row%0d_state", i), {29'h0, status[2:0]},
               {29'h0, tbl[i].st});
         check($sformatf("row%0d_we", i), {31'h0, we}, {31'h0, tbl[i].we});
         check($sformatf("row%0d_en", i), {31'h0, en}, {31'h0, tbl[i].we});
         check($sformatf("row%0d_addr", i), {16'h0, address},
               {16'h0, tbl[i].addr});
         if (i == 1) begin
            check("zero_cap_done", {31'h0, status[3]}, 32'h1);
            check("zero_cap_trig", {31'h0, status[4]}, 32'h1);
            check("zero_cap_taddr", {16'h0, status1[15:0]}, 32'h0);
         end
      end

      // Reset while armed, with live data on the probes.
      control = '0;
      datain  = 8'hFF;
      resetn  = 1'b0;
      tick();
      check_reset_outputs("armed_reset");
      resetn = 1'b1;
      datain = '0;
      tick();

      // Edge trigger on ch2 rising, pre 5, post 10.
      config1 = 32'h000A0005;
      config0 = 32'h0000001A;
      control = 32'h1;
      tick();
      control = '0;
      for (int i = 0; i < 10; i++) tick();
      datain = 8'h04;
      posts = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (status[2:0] == 3'd3 && we) posts++;
         if (status[3]) break;
      end
      check("edge_done", {31'h0, status[3]}, 32'h1);
      check("edge_taddr_ge5", {31'h0, status1[15:0] >= 16'd5}, 32'h1);
      check("edge_taddr", {16'h0, status1[15:0]}, 32'd11);
      // trigger sample plus ten post-trigger samples
      check("edge_writes", posts + 1, 32'd11);
      check("edge_we_off", {31'h0, we}, 32'h0);
      check("edge_final_addr", {16'h0, address}, 32'd22);
      check("edge_state", {29'h0, status[2:0]}, 32'd4);

`ifdef PATTERN_TRIGGER_EN
      config1 = 32'h00020000;
      config0 = 32'h008B0000;
      datain  = 8'h08;
      control = 32'h1;
      tick();
      control = '0;
      for (int i = 0; i < 200; i++) begin
         if (i % 4 == 0) datain[0] = ~datain[0];
         tick();
      end
      check("pat_no_trig", {31'h0, status[4]}, 32'h0);
      check("pat_armed", {29'h0, status[2:0]}, 32'd2);
      datain[1] = 1'b1;
      tick();
      tick();
      check("pat_hold_no_trig", {31'h0, status[4]}, 32'h0);
      datain[0] = ~datain[0];
      tick();
      tick();
      check("pat_trig", {31'h0, status[4]}, 32'h1);
      check("pat_post", {29'h0, status[2:0]}, 32'd3);
      check("pat_taddr", {16'h0, status1[15:0]}, 32'd203);
`else
      config1 = 32'h00020000;
      config0 = 32'hFFFF0018;
      datain  = 8'h00;
      control = 32'h1;
      tick();
      control = '0;
      tick();
      check("nopat_no_trig", {31'h0, status[4]}, 32'h0);
      check("nopat_armed", {29'h0, status[2:0]}, 32'd2);
      datain = 8'h01;
      tick();
      tick();
      check("nopat_trig", {31'h0, status[4]}, 32'h1);
      check("nopat_post", {29'h0, status[2:0]}, 32'd3);
      check("nopat_taddr", {16'h0, status1[15:0]}, 32'd2);
`endif

      // Armed with no trigger long enough to wrap the address.
      control = 32'h2;
      tick();
      control = '0;
      config1 = '0;
      config0 = 32'h18;
      datain  = '0;
      tick();
      control = 32'h1;
      tick();
      control = '0;
      check("wrap_start_addr", {16'h0, address}, 32'h0);
      for (int i = 0; i < 65535; i++) tick();
      check("wrap_top", {16'h0, address}, 32'hFFFF);
      check("wrap_cur_field", {16'h0, status1[31:16]}, 32'hFFFF);
      tick();
      check("wrap_zero", {16'h0, address}, 32'h0);
      check("wrap_armed", {29'h0, status[2:0]}, 32'd2);
      control = 32'h2;
      tick();
      check("wrap_abort", {29'h0, status[2:0]}, 32'd0);
      control = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
